// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Optional feature macro used by the responder: DMEM_TOHOST_EN.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    localparam logic [3:0] BE_WORD = 4'b1111;
    localparam logic [3:0] BE_NONE = 4'b0000;

    // Range check done in 33 bits so a window near the top of the address
    // space cannot wrap around 32'hFFFF_FFFF.
    function automatic logic in_range(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input int unsigned depth);
        logic [32:0] lo;
        logic [32:0] hi;
        logic [32:0] a;
        lo = {1'b0, base};
        hi = lo + (33'(depth) << 2);
        a  = {1'b0, addr};
        return (a >= lo) && (a < hi);
    endfunction

    // Expand byte enables into a 32-bit bit mask.
    function automatic logic [31:0] be_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Synchronous single-port word RAM with byte-enable writes and a
// registered read address. Contents are not reset.
module dmem_array #(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned AW          = 12
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0]   mem_r [DEPTH_WORDS];
    logic [AW-1:0] addr_r;

    // Capture the access address and commit enabled bytes on a write.
    always_ff @(posedge clk) begin
        if (en) begin
            addr_r <= addr;
            if (we) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) begin
                        mem_r[addr][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end
        end
    end

    assign rdata = mem_r[addr_r];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: target side of the CPU load/store interface.
// Accepts one request at a time, waits WAIT_CYCLES, then responds.
// Optional macro DMEM_TOHOST_EN adds a sticky halt register at TOHOST_ADDR.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [31:0] TOHOST_ADDR = 32'h0000_FFF0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
`ifdef DMEM_TOHOST_EN
    ,
    output logic        halt,
    output logic [31:0] tohost_code
`endif
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_LOAD =
        4'((WAIT_CYCLES == 32'd0) ? 32'd0 : (WAIT_CYCLES - 32'd1));
`ifdef DMEM_TOHOST_EN
    localparam logic TH_EN = 1'b1;
`else
    localparam logic TH_EN = 1'b0;
`endif

    dmem_state_t state_r;
    logic [3:0]  cnt_r;
    logic        we_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic [3:0]  be_r;
    logic        req_ready_r;
    logic        rsp_valid_r;
    logic        rsp_err_r;
    logic        rd_ok_r;

    logic        cur_we_s;
    logic [31:0] cur_addr_s;
    logic [31:0] cur_wdata_s;
    logic [3:0]  cur_be_s;
    logic        accept_s;
    logic        commit_s;
    logic        rsp_done_s;
    logic        misal_s;
    logic        range_s;
    logic        is_th_s;
    logic        err_s;
    logic        ram_en_s;
    logic [AW-1:0] widx_s;
    logic [31:0] ram_rdata_s;
    logic [31:0] rdata_s;

`ifdef DMEM_TOHOST_EN
    logic        halt_r;
    logic [31:0] tohost_code_r;
    logic        rd_th_r;
`endif

    // Use live request fields when committing straight out of IDLE
    // (zero wait states), otherwise the copy latched at accept.
    always_comb begin
        cur_we_s    = we_r;
        cur_addr_s  = addr_r;
        cur_wdata_s = wdata_r;
        cur_be_s    = be_r;
        if (state_r == IDLE) begin
            cur_we_s    = req_we;
            cur_addr_s  = req_addr;
            cur_wdata_s = req_wdata;
            cur_be_s    = req_be;
        end else begin
            cur_we_s    = we_r;
            cur_addr_s  = addr_r;
            cur_wdata_s = wdata_r;
            cur_be_s    = be_r;
        end
    end

    // Handshake qualifiers and the edge on which the access commits.
    always_comb begin
        accept_s   = req_valid & req_ready_r;
        rsp_done_s = rsp_valid_r & rsp_ready;
        commit_s   = 1'b0;
        case (state_r)
            IDLE:    commit_s = accept_s & (WAIT_CYCLES == 32'd0);
            WAIT:    commit_s = (cnt_r == 4'd0);
            default: commit_s = 1'b0;
        endcase
    end

    // Address decode: alignment, window, halt register, word index.
    always_comb begin
        misal_s  = (cur_addr_s[1:0] != 2'b00);
        range_s  = in_range(cur_addr_s, BASE_ADDR, DEPTH_WORDS);
        is_th_s  = TH_EN & (cur_addr_s == TOHOST_ADDR) & ~misal_s;
        err_s    = ~is_th_s & (misal_s | ~range_s);
        widx_s   = AW'((cur_addr_s - BASE_ADDR) >> 2);
        ram_en_s = commit_s & ~err_s & ~is_th_s & ~rst;
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk   (clk),
        .en    (ram_en_s),
        .we    (cur_we_s),
        .be    (cur_be_s),
        .addr  (widx_s),
        .wdata (cur_wdata_s),
        .rdata (ram_rdata_s)
    );

    // Request/response FSM with registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= 4'd0;
            we_r        <= 1'b0;
            addr_r      <= 32'h0;
            wdata_r     <= 32'h0;
            be_r        <= 4'b0000;
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rd_ok_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        we_r        <= req_we;
                        addr_r      <= req_addr;
                        wdata_r     <= req_wdata;
                        be_r        <= req_be;
                        req_ready_r <= 1'b0;
                        if (WAIT_CYCLES == 32'd0) begin
                            state_r <= RESP;
                        end else begin
                            state_r <= WAIT;
                            cnt_r   <= WAIT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_r == 4'd0) begin
                        state_r <= RESP;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_done_s) begin
                        state_r     <= IDLE;
                        req_ready_r <= 1'b1;
                        rsp_valid_r <= 1'b0;
                        rsp_err_r   <= 1'b0;
                        rd_ok_r     <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    req_ready_r <= 1'b1;
                    rsp_valid_r <= 1'b0;
                    rsp_err_r   <= 1'b0;
                    rd_ok_r     <= 1'b0;
                end
            endcase
            // Response fields are captured once, on the commit edge.
            if (commit_s) begin
                rsp_valid_r <= 1'b1;
                rsp_err_r   <= err_s;
                rd_ok_r     <= ~err_s & ~cur_we_s & ~is_th_s;
            end
        end
    end

`ifdef DMEM_TOHOST_EN
    // Sticky halt register: written on the commit edge of a tohost store.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halt_r        <= 1'b0;
            tohost_code_r <= 32'h0;
            rd_th_r       <= 1'b0;
        end else begin
            if (commit_s && is_th_s) begin
                rd_th_r <= ~cur_we_s;
                if (cur_we_s) begin
                    halt_r        <= 1'b1;
                    tohost_code_r <= cur_wdata_s & be_mask(cur_be_s);
                end
            end else if (rsp_done_s) begin
                rd_th_r <= 1'b0;
            end
        end
    end

    assign halt        = halt_r;
    assign tohost_code = tohost_code_r;
`endif

    // Read data is zero unless the response carries a successful read.
    always_comb begin
        rdata_s = 32'h0;
        if (rd_ok_r) begin
            rdata_s = ram_rdata_s;
        end else begin
            rdata_s = 32'h0;
        end
`ifdef DMEM_TOHOST_EN
        if (rd_th_r) begin
            rdata_s = tohost_code_r;
        end else begin
            rdata_s = rdata_s;
        end
`endif
    end

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rdata_s;
    assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: vector table on a WAIT_CYCLES=1
// instance plus hand sequences; a WAIT_CYCLES=3 instance covers reset
// during WAIT/RESP. Honours DMEM_TOHOST_EN when defined.
module tb_dmem_responder;
    import dmem_pkg::*;

`ifdef DMEM_TOHOST_EN
    localparam logic TH_EN = 1'b1;
`else
    localparam logic TH_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        sel;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_ready;

    logic        a_req_valid, a_rsp_ready, a_req_ready, a_rsp_valid, a_rsp_err;
    logic [31:0] a_rsp_rdata;
    logic        b_req_valid, b_rsp_ready, b_req_ready, b_rsp_valid, b_rsp_err;
    logic [31:0] b_rsp_rdata;
    logic        m_req_ready, m_rsp_valid, m_rsp_err;
    logic [31:0] m_rsp_rdata;
`ifdef DMEM_TOHOST_EN
    logic        a_halt, b_halt;
    logic [31:0] a_tohost_code, b_tohost_code;
`endif

    int n_checks;
    int n_fail;

    assign a_req_valid = req_valid & ~sel;
    assign b_req_valid = req_valid & sel;
    assign a_rsp_ready = rsp_ready & ~sel;
    assign b_rsp_ready = rsp_ready & sel;
    assign m_req_ready = sel ? b_req_ready : a_req_ready;
    assign m_rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
    assign m_rsp_err   = sel ? b_rsp_err   : a_rsp_err;
    assign m_rsp_rdata = sel ? b_rsp_rdata : a_rsp_rdata;

    dmem_responder #(.WAIT_CYCLES(1)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
        .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
`ifdef DMEM_TOHOST_EN
        , .halt(a_halt), .tohost_code(a_tohost_code)
`endif
    );

    dmem_responder #(.WAIT_CYCLES(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
        .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
`ifdef DMEM_TOHOST_EN
        , .halt(b_halt), .tohost_code(b_tohost_code)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Present a request (called at a negedge); returns at the negedge after the accept edge.
    task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, output logic ok);
        int n;
        req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        req_valid = 1'b1;
        n = 0;
        while (!m_req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        req_valid = 1'b0;
        ok = (n < 50);
    endtask

    // Count cycles from accept until rsp_valid (1 = first cycle after accept).
    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!m_rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic ack();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input int exp_lat,
                          output logic [31:0] rdata, output logic err, input string tag);
        logic ok;
        int   lat;
        send(we, addr, wdata, be, ok);
        check({tag, " accepted"}, 32'(ok), 32'd1);
        wait_rsp(lat);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        rdata = m_rsp_rdata;
        err   = m_rsp_err;
        ack();
        check({tag, " back to idle"}, {30'd0, m_rsp_valid, m_req_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        logic        ok;
        int          lat;
        int          seen;

        n_checks = 0; n_fail = 0;
        sel = 1'b0; rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        req_be = BE_NONE; rsp_ready = 1'b0;

        vecs[0]  = '{1'b1, 32'h0001_0000, 32'h0BAD_F00D, BE_WORD, 32'h0, 1'b0};
        vecs[1]  = '{1'b1, 32'h0001_0004, 32'hDEAD_BEEF, BE_WORD, 32'h0, 1'b0};
        vecs[2]  = '{1'b0, 32'h0001_0004, 32'h0,         BE_WORD, 32'hDEAD_BEEF, 1'b0};
        vecs[3]  = '{1'b1, 32'h0001_0004, 32'h1122_3344, 4'b0101, 32'h0, 1'b0};
        vecs[4]  = '{1'b0, 32'h0001_0004, 32'h0,         4'b0000, 32'hDE22_BE44, 1'b0};
        vecs[5]  = '{1'b0, 32'h0001_0002, 32'h0,         BE_WORD, 32'h0, 1'b1};
        vecs[6]  = '{1'b1, 32'h0001_4000, 32'hFFFF_FFFF, BE_WORD, 32'h0, 1'b1};
        vecs[7]  = '{1'b0, 32'h0001_0000, 32'h0,         BE_WORD, 32'h0BAD_F00D, 1'b0};
        vecs[8]  = '{1'b0, 32'hFFFF_FFFC, 32'h0,         BE_WORD, 32'h0, 1'b1};
        vecs[9]  = '{1'b1, 32'h0001_0004, 32'h0,         BE_NONE, 32'h0, 1'b0};
        vecs[10] = '{1'b0, 32'h0001_0004, 32'h0,         BE_WORD, 32'hDE22_BE44, 1'b0};
        vecs[11] = '{1'b1, 32'h0001_3FFC, 32'h1234_5678, BE_WORD, 32'h0, 1'b0};
        vecs[12] = '{1'b0, 32'h0001_3FFC, 32'h0,         BE_WORD, 32'h1234_5678, 1'b0};
        vecs[13] = '{1'b0, 32'h0000_FFFC, 32'h0,         BE_WORD, 32'h0, 1'b1};
        vecs[14] = '{1'b0, 32'h0000_FFF0, 32'h0,         BE_WORD, 32'h0, ~TH_EN};
        vecs[15] = '{1'b1, 32'h0001_0001, 32'hFFFF_FFFF, BE_WORD, 32'h0, 1'b1};
        vecs[16] = '{1'b0, 32'h0001_0000, 32'h0,         BE_WORD, 32'h0BAD_F00D, 1'b0};

        // Reset for one cycle.
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset req_ready", 32'(a_req_ready), 32'd1);
        check("reset rsp_valid", 32'(a_rsp_valid), 32'd0);
        check("reset rsp_rdata", a_rsp_rdata, 32'h0);
        check("reset rsp_err", 32'(a_rsp_err), 32'd0);
`ifdef DMEM_TOHOST_EN
        check("reset halt", 32'(a_halt), 32'd0);
`endif

        // Vector table on the one-wait-state instance.
        for (int i = 0; i < 17; i++) begin
            access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, 2, rd, er,
                   $sformatf("vec%0d", i));
            check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d err", i), 32'(er), 32'(vecs[i].exp_err));
        end

        // rsp_ready while idle does nothing.
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("idle rsp_ready valid", 32'(m_rsp_valid), 32'd0);
        check("idle rsp_ready ready", 32'(m_req_ready), 32'd1);
        rsp_ready = 1'b0;

        // Backpressure: response held for five cycles.
        send(1'b0, 32'h0001_0004, 32'h0, BE_WORD, ok);
        check("bp accepted", 32'(ok), 32'd1);
        check("bp req_ready in wait", 32'(m_req_ready), 32'd0);
        wait_rsp(lat);
        check("bp latency", 32'(lat), 32'd2);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp%0d valid", i), 32'(m_rsp_valid), 32'd1);
            check($sformatf("bp%0d rdata", i), m_rsp_rdata, 32'hDE22_BE44);
            check($sformatf("bp%0d err", i), 32'(m_rsp_err), 32'd0);
            check($sformatf("bp%0d req_ready", i), 32'(m_req_ready), 32'd0);
            @(negedge clk);
        end
        ack();
        check("bp release valid", 32'(m_rsp_valid), 32'd0);
        check("bp release ready", 32'(m_req_ready), 32'd1);

`ifdef DMEM_TOHOST_EN
        access(1'b1, 32'h0000_FFF0, 32'h0000_0001, BE_WORD, 2, rd, er, "tohost wr");
        check("tohost wr err", 32'(er), 32'd0);
        check("tohost halt", 32'(a_halt), 32'd1);
        check("tohost code", a_tohost_code, 32'h1);
        access(1'b0, 32'h0000_FFF0, 32'h0, BE_WORD, 2, rd, er, "tohost rd");
        check("tohost rd data", rd, 32'h1);
        repeat (3) @(negedge clk);
        check("tohost halt sticky", 32'(a_halt), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("tohost halt cleared", 32'(a_halt), 32'd0);
        check("tohost code cleared", a_tohost_code, 32'h0);
`endif

        // Three-wait-state instance: latency and reset during WAIT/RESP.
        sel = 1'b1;
        @(negedge clk);
        access(1'b1, 32'h0001_0008, 32'h0, BE_WORD, 4, rd, er, "w3 init");
        check("w3 init err", 32'(er), 32'd0);

        send(1'b1, 32'h0001_000C, 32'h0A0A_0A0A, BE_WORD, ok);
        wait_rsp(lat);
        check("w3 resp latency", 32'(lat), 32'd4);
        rst = 1'b1;
        #1;
        check("rst in resp valid", 32'(m_rsp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst in resp ready", 32'(m_req_ready), 32'd1);
        @(negedge clk);

        send(1'b1, 32'h0001_0008, 32'h5555_5555, BE_WORD, ok);
        check("w3 abort accepted", 32'(ok), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (m_rsp_valid) seen++;
        end
        check("rst in wait no response", 32'(seen), 32'd0);

        access(1'b0, 32'h0001_0008, 32'h0, BE_WORD, 4, rd, er, "w3 rd aborted");
        check("aborted write discarded", rd, 32'h0);
        check("aborted rd err", 32'(er), 32'd0);
        access(1'b0, 32'h0001_000C, 32'h0, BE_WORD, 4, rd, er, "w3 rd committed");
        check("committed write kept", rd, 32'h0A0A_0A0A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
